// File: rtl/prod_unload.sv
// Drains result words through a small FIFO and serializes each word into two bytes
// on a valid/ready byte stream, counting fully delivered words.
module prod_unload #(
  parameter int WORD_W    = 16,
  parameter int BYTE_W    = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              sclr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        words_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg;
  state_t            state_reg;
  logic [BYTE_W-1:0] out_data_reg, second_reg;
  logic              out_valid_reg, out_last_reg;
  logic [7:0]        words_done_reg;

  logic              push, pop, head_avail;
  logic [WORD_W-1:0] head;
  logic [BYTE_W-1:0] head_first, head_second;

  assign head_avail = (count_reg != '0);
  assign in_ready   = (count_reg < FULL_CNT);
  assign push       = in_valid & in_ready;
  // The FSM pulls the head either from IDLE or back-to-back at the end of a word.
  assign pop        = head_avail &&
                      ((state_reg == IDLE) || ((state_reg == SECOND) && out_ready));
  assign head       = mem[rd_ptr_reg];

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign head_first  = head[2*BYTE_W-1:BYTE_W];
      assign head_second = head[BYTE_W-1:0];
    end else begin : g_lsb_first
      assign head_first  = head[BYTE_W-1:0];
      assign head_second = head[2*BYTE_W-1:BYTE_W];
    end
  endgenerate

  // Storage is not reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (!sclr_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_reg      <= IDLE;
      out_data_reg   <= '0;
      second_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      words_done_reg <= '0;
    end else if (!sclr_n) begin
      state_reg      <= IDLE;
      out_data_reg   <= '0;
      second_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      words_done_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (head_avail) begin
            out_data_reg  <= head_first;
            second_reg    <= head_second;
            out_valid_reg <= 1'b1;
            out_last_reg  <= 1'b0;
            state_reg     <= FIRST;
          end
        end
        FIRST: begin
          if (out_ready) begin
            out_data_reg <= second_reg;
            out_last_reg <= 1'b1;
            state_reg    <= SECOND;
          end
        end
        SECOND: begin
          if (out_ready) begin
            words_done_reg <= words_done_reg + 8'd1;
            out_last_reg   <= 1'b0;
            if (head_avail) begin
              out_data_reg <= head_first;
              second_reg   <= head_second;
              state_reg    <= FIRST;
            end else begin
              out_valid_reg <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_last   = out_last_reg;
  assign words_done = words_done_reg;
  assign busy       = head_avail | out_valid_reg;

endmodule
